srm_ctrl: RTL and testbench

Instruction register, decoder and control FSM for the Simple RISC Machine. Sits directly upstream of the datapath and replaces the switch-driven control interface. Latches a 16-bit instruction and, on start, sequences the datapath through operand read, execute and writeback stages. Drives every datapath control input plus datapath_in, which carries the sign-extended 8-bit immediate.

---
 rtl/srm_ctrl_pkg.sv | 69 ++++++
 rtl/srm_decoder.sv | 32 +++
 rtl/srm_ctrl.sv | 145 ++++++++++++++
 tb/tb_srm_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/srm_ctrl_pkg.sv
// Shared definitions for the Simple RISC Machine controller.
// Holds the FSM state encodings, opcode/sub-opcode constants, ALU and shift
// codes, the word width, and the instruction classifier used by the decoder.
package srm_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;

  // FSM state encodings
  localparam logic [2:0] S_WAIT      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_GET_A     = 3'd2;
  localparam logic [2:0] S_GET_B     = 3'd3;
  localparam logic [2:0] S_EXEC      = 3'd4;
  localparam logic [2:0] S_WRITE_REG = 3'd5;
  localparam logic [2:0] S_WRITE_IMM = 3'd6;

  // Opcode field IR[15:13]
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // Sub-opcode field IR[12:11]
  localparam logic [1:0] SUB_MOV_REG = 2'b00;
  localparam logic [1:0] SUB_MOV_IMM = 2'b10;
  localparam logic [1:0] SUB_ADD     = 2'b00;
  localparam logic [1:0] SUB_CMP     = 2'b01;
  localparam logic [1:0] SUB_AND     = 2'b10;
  localparam logic [1:0] SUB_MVN     = 2'b11;

  // ALU operation codes (the 101 ops map sub directly onto these)
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  // Shifter codes
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    CLS_UNDEF   = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } instr_cls_t;

  function automatic instr_cls_t classify(input logic [2:0] op, input logic [1:0] sub);
    instr_cls_t c;
    c = CLS_UNDEF;
    if (op == OP_MOV) begin
      if (sub == SUB_MOV_IMM)      c = CLS_MOV_IMM;
      else if (sub == SUB_MOV_REG) c = CLS_MOV_REG;
    end else if (op == OP_ALU) begin
      case (sub)
        SUB_ADD: c = CLS_ADD;
        SUB_CMP: c = CLS_CMP;
        SUB_AND: c = CLS_AND;
        default: c = CLS_MVN;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/srm_decoder.sv
// Combinational instruction decoder.
// Ports:
//   ir      in  16  instruction register contents
//   rn      out 3   IR[10:8]
//   rd      out 3   IR[7:5]
//   rm      out 3   IR[2:0]
//   sh      out 2   IR[4:3]
//   sub     out 2   IR[12:11]
//   sximm8  out 16  IR[7:0] sign-extended
//   cls     out     instruction class (undefined for unsupported op/sub)
module srm_decoder
  import srm_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] ir,
  output logic [REG_W-1:0]  rn,
  output logic [REG_W-1:0]  rd,
  output logic [REG_W-1:0]  rm,
  output logic [1:0]        sh,
  output logic [1:0]        sub,
  output logic [WORD_W-1:0] sximm8,
  output instr_cls_t        cls
);

  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign sh     = ir[4:3];
  assign sub    = ir[12:11];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign cls    = classify(ir[15:13], ir[12:11]);

endmodule

// File: rtl/srm_ctrl.sv
// Instruction register, decoder and Moore control FSM for the Simple RISC
// Machine. Captures an instruction in WAIT, and on start walks the datapath
// through operand read, execute and writeback.
//
// Handshake: the controller is idle and accepts work only while w=1 (WAIT).
// In WAIT, load=1 captures in into IR on the clock edge and s=1 starts
// execution on the same edge (using the newly captured word if both are
// high). Outside WAIT, s and load are ignored.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   s, load, in        start, IR load, instruction word
//   w                  1 only in WAIT
//   datapath_in        sign-extended IR[7:0]
//   readnum/writenum   register-file read/write index
//   write, vsel        register-file write enable, writeback select
//   loada/loadb/loadc/loads  datapath register enables
//   asel, bsel         operand selects (bsel fixed at 0)
//   shift, ALUop       shifter and ALU operation
module srm_ctrl
  import srm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              s,
  input  logic              load,
  input  logic [WORD_W-1:0] in,
  output logic              w,
  output logic [WORD_W-1:0] datapath_in,
  output logic [REG_W-1:0]  readnum,
  output logic [REG_W-1:0]  writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads
);

  logic [WORD_W-1:0] ir;
  logic [2:0]        state;
  logic [2:0]        state_next;

  logic [REG_W-1:0]  rn, rd, rm;
  logic [1:0]        sh, sub;
  logic [WORD_W-1:0] sximm8;
  instr_cls_t        cls;

  srm_decoder u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .sub    (sub),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  // IR only updates while idle so an instruction cannot change mid-flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir    <= '0;
      state <= S_WAIT;
    end else begin
      state <= state_next;
      if (load && (state == S_WAIT)) ir <= in;
    end
  end

  always_comb begin
    state_next = S_WAIT;
    case (state)
      S_WAIT:   state_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:                 state_next = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN:        state_next = S_GET_B;
          CLS_ADD, CLS_CMP, CLS_AND:   state_next = S_GET_A;
          default:                     state_next = S_WAIT;
        endcase
      end
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_EXEC;
      S_EXEC:      state_next = (cls == CLS_CMP) ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
      S_WRITE_IMM: state_next = S_WAIT;
      default:     state_next = S_WAIT;
    endcase
  end

  assign datapath_in = sximm8;
  assign bsel        = 1'b0;

  // Moore outputs: depend on state and IR only.
  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    loadc    = 1'b0;
    loads    = 1'b0;
    case (state)
      S_WAIT: w = 1'b1;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = sh;
        loadc = (cls != CLS_CMP);
        loads = (cls == CLS_CMP);
        // MOV reg is computed as 0 + shifted Rm, MVN as NOT shifted Rm.
        ALUop = (cls == CLS_MOV_REG) ? ALU_ADD : sub;
        asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = 1'b0;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_srm_ctrl.sv
// Bench for srm_ctrl: a per-cycle vector table of {inputs, expected outputs}
// followed by hand-written multi-cycle latency sequences.
module tb_srm_ctrl;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [15:0] datapath_in;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, alu_op;

  srm_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .s           (s),
    .load        (load),
    .in          (in),
    .w           (w),
    .datapath_in (datapath_in),
    .readnum     (readnum),
    .writenum    (writenum),
    .write       (write),
    .vsel        (vsel),
    .loada       (loada),
    .loadb       (loadb),
    .asel        (asel),
    .bsel        (bsel),
    .shift       (shift),
    .ALUop       (alu_op),
    .loadc       (loadc),
    .loads       (loads)
  );

  // clock block
  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [15:0] dp;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
  } obs_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        s;
    logic        ld;
    logic [15:0] in;
    obs_t        e;
  } vec_t;

  vec_t vec_q[$];
  obs_t act;
  int   checks = 0;
  int   passed = 0;

  always_comb begin
    act          = '0;
    act.w        = w;
    act.dp       = datapath_in;
    act.readnum  = readnum;
    act.writenum = writenum;
    act.write    = write;
    act.vsel     = vsel;
    act.loada    = loada;
    act.loadb    = loadb;
    act.asel     = asel;
    act.bsel     = bsel;
    act.shift    = shift;
    act.aluop    = alu_op;
    act.loadc    = loadc;
    act.loads    = loads;
  end

  // expected-output builders, one per FSM state
  function automatic obs_t o_wait(input logic [15:0] dp);
    obs_t o = '0; o.w = 1'b1; o.dp = dp; return o;
  endfunction
  function automatic obs_t o_dec(input logic [15:0] dp);
    obs_t o = '0; o.dp = dp; return o;
  endfunction
  function automatic obs_t o_ga(input logic [2:0] rn, input logic [15:0] dp);
    obs_t o = '0; o.dp = dp; o.readnum = rn; o.loada = 1'b1; return o;
  endfunction
  function automatic obs_t o_gb(input logic [2:0] rm, input logic [15:0] dp);
    obs_t o = '0; o.dp = dp; o.readnum = rm; o.loadb = 1'b1; return o;
  endfunction
  function automatic obs_t o_ex(input logic [1:0] sh, input logic [1:0] alu, input logic as,
                                input logic lc, input logic ls, input logic [15:0] dp);
    obs_t o = '0;
    o.dp = dp; o.shift = sh; o.aluop = alu; o.asel = as; o.loadc = lc; o.loads = ls;
    return o;
  endfunction
  function automatic obs_t o_wr(input logic [2:0] rd, input logic [15:0] dp);
    obs_t o = '0; o.dp = dp; o.writenum = rd; o.write = 1'b1; return o;
  endfunction
  function automatic obs_t o_wi(input logic [2:0] rn, input logic [15:0] dp);
    obs_t o = '0; o.dp = dp; o.writenum = rn; o.vsel = 1'b1; o.write = 1'b1; return o;
  endfunction

  task automatic add(input string nm, input logic r, input logic st, input logic l,
                     input logic [15:0] i, input obs_t e);
    vec_t v;
    v.name = nm; v.rst = r; v.s = st; v.ld = l; v.in = i; v.e = e;
    vec_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  // Load an instruction, pulse s, then count edges after the s-sampling edge
  // until w returns high, and count cycles with write asserted.
  task automatic run_latency(input string nm, input logic [15:0] instr,
                             input int exp_lat, input int exp_writes);
    int cnt;
    int writes;
    load = 1'b1; in = instr; tick();
    load = 1'b0; s = 1'b1; tick();
    s = 1'b0;
    cnt = 0; writes = 0;
    while (!w && cnt < 20) begin
      if (write) writes++;
      tick();
      cnt++;
    end
    check_int({nm, "_latency"}, cnt, exp_lat);
    check_int({nm, "_writes"}, writes, exp_writes);
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;

    add("reset",          1, 0, 0, 16'h0000, o_wait(16'h0000));
    // MOV R0,#7
    add("ld_d007",        0, 0, 1, 16'hD007, o_wait(16'h0007));
    add("movi7_decode",   0, 1, 0, 16'h0000, o_dec(16'h0007));
    add("movi7_wrimm",    0, 0, 0, 16'h0000, o_wi(3'd0, 16'h0007));
    add("movi7_wait",     0, 0, 0, 16'h0000, o_wait(16'h0007));
    // MOV R1,#-2
    add("ld_d1fe",        0, 0, 1, 16'hD1FE, o_wait(16'hFFFE));
    add("movim2_decode",  0, 1, 0, 16'h0000, o_dec(16'hFFFE));
    add("movim2_wrimm",   0, 0, 0, 16'h0000, o_wi(3'd1, 16'hFFFE));
    add("movim2_wait",    0, 0, 0, 16'h0000, o_wait(16'hFFFE));
    // ADD R2,R1,R0,LSL#1
    add("ld_a148",        0, 0, 1, 16'hA148, o_wait(16'h0048));
    add("add_decode",     0, 1, 0, 16'h0000, o_dec(16'h0048));
    add("add_get_a",      0, 0, 0, 16'h0000, o_ga(3'd1, 16'h0048));
    add("add_get_b",      0, 0, 0, 16'h0000, o_gb(3'd0, 16'h0048));
    add("add_exec",       0, 0, 0, 16'h0000, o_ex(2'b01, 2'b00, 0, 1, 0, 16'h0048));
    add("add_wrreg",      0, 0, 0, 16'h0000, o_wr(3'd2, 16'h0048));
    add("add_wait",       0, 0, 0, 16'h0000, o_wait(16'h0048));
    // CMP R1,R0
    add("ld_a900",        0, 0, 1, 16'hA900, o_wait(16'h0000));
    add("cmp_decode",     0, 1, 0, 16'h0000, o_dec(16'h0000));
    add("cmp_get_a",      0, 0, 0, 16'h0000, o_ga(3'd1, 16'h0000));
    add("cmp_get_b",      0, 0, 0, 16'h0000, o_gb(3'd0, 16'h0000));
    add("cmp_exec",       0, 0, 0, 16'h0000, o_ex(2'b00, 2'b01, 0, 0, 1, 16'h0000));
    add("cmp_wait",       0, 0, 0, 16'h0000, o_wait(16'h0000));
    // MOV R3,R1
    add("ld_c061",        0, 0, 1, 16'hC061, o_wait(16'h0061));
    add("movr_decode",    0, 1, 0, 16'h0000, o_dec(16'h0061));
    add("movr_get_b",     0, 0, 0, 16'h0000, o_gb(3'd1, 16'h0061));
    add("movr_exec",      0, 0, 0, 16'h0000, o_ex(2'b00, 2'b00, 1, 1, 0, 16'h0061));
    add("movr_wrreg",     0, 0, 0, 16'h0000, o_wr(3'd3, 16'h0061));
    add("movr_wait",      0, 0, 0, 16'h0000, o_wait(16'h0061));
    // load+s together, then load attempts mid-flight must be ignored
    add("lds_a148",       0, 1, 1, 16'hA148, o_dec(16'h0048));
    add("add2_get_a",     0, 0, 0, 16'h0000, o_ga(3'd1, 16'h0048));
    add("add2_get_b_ld",  0, 0, 1, 16'hD0FF, o_gb(3'd0, 16'h0048));
    add("add2_exec_ld",   0, 0, 1, 16'hD0FF, o_ex(2'b01, 2'b00, 0, 1, 0, 16'h0048));
    add("add2_wrreg",     0, 0, 0, 16'h0000, o_wr(3'd2, 16'h0048));
    add("add2_wait",      0, 0, 0, 16'h0000, o_wait(16'h0048));
    // MVN R7,R2,LSR#1
    add("ld_b8f2",        0, 0, 1, 16'hB8F2, o_wait(16'hFFF2));
    add("mvn_decode",     0, 1, 0, 16'h0000, o_dec(16'hFFF2));
    add("mvn_get_b",      0, 0, 0, 16'h0000, o_gb(3'd2, 16'hFFF2));
    add("mvn_exec",       0, 0, 0, 16'h0000, o_ex(2'b10, 2'b11, 1, 1, 0, 16'hFFF2));
    add("mvn_wrreg",      0, 0, 0, 16'h0000, o_wr(3'd7, 16'hFFF2));
    add("mvn_wait",       0, 0, 0, 16'h0000, o_wait(16'hFFF2));
    // AND R4,R3,R5,ASR#1
    add("ld_b39d",        0, 0, 1, 16'hB39D, o_wait(16'hFF9D));
    add("and_decode",     0, 1, 0, 16'h0000, o_dec(16'hFF9D));
    add("and_get_a",      0, 0, 0, 16'h0000, o_ga(3'd3, 16'hFF9D));
    add("and_get_b",      0, 0, 0, 16'h0000, o_gb(3'd5, 16'hFF9D));
    add("and_exec",       0, 0, 0, 16'h0000, o_ex(2'b11, 2'b10, 0, 1, 0, 16'hFF9D));
    add("and_wrreg",      0, 0, 0, 16'h0000, o_wr(3'd4, 16'hFF9D));
    add("and_wait",       0, 0, 0, 16'h0000, o_wait(16'hFF9D));
    // s held high: WAIT re-executes, s ignored elsewhere
    add("ld_d1fe_b",      0, 0, 1, 16'hD1FE, o_wait(16'hFFFE));
    add("hold_decode1",   0, 1, 0, 16'h0000, o_dec(16'hFFFE));
    add("hold_wrimm1",    0, 1, 0, 16'h0000, o_wi(3'd1, 16'hFFFE));
    add("hold_wait1",     0, 1, 0, 16'h0000, o_wait(16'hFFFE));
    add("hold_decode2",   0, 1, 0, 16'h0000, o_dec(16'hFFFE));
    add("hold_wrimm2",    0, 0, 0, 16'h0000, o_wi(3'd1, 16'hFFFE));
    add("hold_wait2",     0, 0, 0, 16'h0000, o_wait(16'hFFFE));
    // undefined instructions
    add("ld_0000",        0, 0, 1, 16'h0000, o_wait(16'h0000));
    add("undef0_decode",  0, 1, 0, 16'h0000, o_dec(16'h0000));
    add("undef0_wait",    0, 1, 0, 16'h0000, o_wait(16'h0000));
    add("ld_c800",        0, 0, 1, 16'hC800, o_wait(16'h0000));
    add("undefc8_decode", 0, 1, 0, 16'h0000, o_dec(16'h0000));
    add("undefc8_wait",   0, 0, 0, 16'h0000, o_wait(16'h0000));
    // reset during GET_B
    add("ld_a148_r",      0, 0, 1, 16'hA148, o_wait(16'h0048));
    add("rst_decode",     0, 1, 0, 16'h0000, o_dec(16'h0048));
    add("rst_get_a",      0, 0, 0, 16'h0000, o_ga(3'd1, 16'h0048));
    add("rst_get_b",      0, 0, 0, 16'h0000, o_gb(3'd0, 16'h0048));
    add("rst_in_get_b",   1, 0, 0, 16'h0000, o_wait(16'h0000));
    add("rst_after",      0, 0, 0, 16'h0000, o_wait(16'h0000));
    add("rst_ir0_decode", 0, 1, 0, 16'h0000, o_dec(16'h0000));
    add("rst_ir0_wait",   0, 0, 0, 16'h0000, o_wait(16'h0000));
    // reset beats load and s on the same edge
    add("rst_over_lds",   1, 1, 1, 16'hD007, o_wait(16'h0000));
    add("rst_over_after", 0, 0, 0, 16'h0000, o_wait(16'h0000));

    foreach (vec_q[i]) begin
      reset = vec_q[i].rst;
      s     = vec_q[i].s;
      load  = vec_q[i].ld;
      in    = vec_q[i].in;
      tick();
      checks++;
      if (act === vec_q[i].e) passed++;
      else $display("FAIL %s: got %h, want %h", vec_q[i].name, act, vec_q[i].e);
    end
    reset = 1'b0; s = 1'b0; load = 1'b0; in = 16'h0000;

    // multi-cycle latency sequences
    run_latency("add", 16'hA148, 5, 1);
    run_latency("cmp", 16'hA900, 4, 0);
    run_latency("movr", 16'hC061, 4, 1);
    run_latency("mvn", 16'hB8F2, 4, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
